// File: rtl/adc_cal_sched.sv
// adc_cal_sched: shares one external single-precision FMA (res = a*b + c) among
// NUM_CH ADC channels. Each sample is converted to volts as sample*gain[ch] + offset[ch].
// Round-robin grant, per-channel coefficient bank, channel tag FIFO so results
// come back labelled with the channel that produced them.
// Optional feature macro: CAL_COEF_SHADOW_EN (double-buffered coefficient bank,
// copied to the active bank on i_cfg_commit).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid, once raised, holds its payload stable until that edge.
`timescale 1ns/1ps
module adc_cal_sched #(
  parameter int NUM_CH  = 4,
  parameter int MAX_OUT = 16,
  localparam int TAG_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_areset,
  input  logic [NUM_CH*32-1:0] i_ch_tdata,
  input  logic [NUM_CH-1:0]   i_ch_tvalid,
  output logic [NUM_CH-1:0]   o_ch_tready,
  input  logic                i_cfg_we,
  input  logic [TAG_W:0]      i_cfg_addr,
  input  logic [31:0]         i_cfg_wdata,
  input  logic                i_cfg_commit,
  output logic [31:0]         o_fma_a_tdata,
  output logic [31:0]         o_fma_b_tdata,
  output logic [31:0]         o_fma_c_tdata,
  output logic                o_fma_tvalid,
  input  logic                i_fma_tready,
  input  logic [31:0]         i_fma_res_tdata,
  input  logic                i_fma_res_tvalid,
  output logic [31:0]         o_res_tdata,
  output logic [TAG_W-1:0]    o_res_tdest,
  output logic                o_res_tvalid,
  output logic                o_busy,
  output logic                o_err,
  input  logic                i_err_clr
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] GAIN_RST = 32'h35a0_0000;
  localparam logic [31:0] OFF_RST  = 32'hc120_0000;

  typedef enum logic {ISSUE_IDLE, ISSUE_HOLD} issue_state_t;

  logic clk, rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  issue_state_t state, state_nxt;
  logic [TAG_W-1:0] rr, grant_ch, tag_q;
  logic             grant_vld, grant_fire, fma_fire, room;
  logic [NUM_CH-1:0] ch_ready;
  logic [31:0]      a_q, b_q, c_q;
  logic [31:0]      gain_act [NUM_CH];
  logic [31:0]      off_act  [NUM_CH];
  logic [TAG_W-1:0] tag_mem  [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] outstanding;
  logic             pop, res_valid_q, err_q;
  logic [31:0]      res_data_q;
  logic [TAG_W-1:0] res_dest_q;
  logic [TAG_W-1:0] cfg_ch;
  logic             cfg_sel, cfg_ok;

  // Outstanding == tag FIFO occupancy; a full FIFO blocks both grant and issue.
  assign room = (outstanding < CNT_W'(MAX_OUT));

  // Round-robin pick: first requester scanning upward from rr+1 with wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!grant_vld && i_ch_tvalid[(int'(rr) + i) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant_ch  = TAG_W'((int'(rr) + i) % NUM_CH);
      end
    end
  end

  // Issue FSM next state: grant in IDLE, wait for the FMA to accept in HOLD.
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    fma_fire   = 1'b0;
    ch_ready   = '0;
    case (state)
      ISSUE_IDLE: begin
        if (grant_vld && room) begin
          grant_fire         = 1'b1;
          ch_ready[grant_ch] = 1'b1;
          state_nxt          = ISSUE_HOLD;
        end
      end
      ISSUE_HOLD: begin
        if (i_fma_tready && room) begin
          fma_fire  = 1'b1;
          state_nxt = ISSUE_IDLE;
        end
      end
      default: state_nxt = ISSUE_IDLE;
    endcase
  end

  // Issue FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ISSUE_IDLE;
    else     state <= state_nxt;
  end

  // Latch sample, coefficients and tag at grant; they stay frozen while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      tag_q <= '0;
      rr    <= TAG_W'(NUM_CH - 1);
    end else if (grant_fire) begin
      a_q   <= i_ch_tdata[int'(grant_ch)*32 +: 32];
      b_q   <= gain_act[grant_ch];
      c_q   <= off_act[grant_ch];
      tag_q <= grant_ch;
      rr    <= grant_ch;
    end
  end

  assign cfg_ch  = i_cfg_addr[TAG_W:1];
  assign cfg_sel = i_cfg_addr[0];
  assign cfg_ok  = i_cfg_we && (int'(cfg_ch) < NUM_CH);

`ifdef CAL_COEF_SHADOW_EN
  logic [31:0] gain_shd [NUM_CH];
  logic [31:0] off_shd  [NUM_CH];

  // Writes land in the shadow bank; commit copies it (including a same-cycle write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        gain_shd[k] <= GAIN_RST;
        off_shd[k]  <= OFF_RST;
        gain_act[k] <= GAIN_RST;
        off_act[k]  <= OFF_RST;
      end
    end else begin
      if (cfg_ok && !cfg_sel) gain_shd[cfg_ch] <= i_cfg_wdata;
      if (cfg_ok && cfg_sel)  off_shd[cfg_ch]  <= i_cfg_wdata;
      if (i_cfg_commit) begin
        for (int k = 0; k < NUM_CH; k++) begin
          gain_act[k] <= (cfg_ok && !cfg_sel && cfg_ch == TAG_W'(k)) ? i_cfg_wdata : gain_shd[k];
          off_act[k]  <= (cfg_ok && cfg_sel  && cfg_ch == TAG_W'(k)) ? i_cfg_wdata : off_shd[k];
        end
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = i_cfg_commit;

  // Writes go straight to the active bank; grants see them from the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        gain_act[k] <= GAIN_RST;
        off_act[k]  <= OFF_RST;
      end
    end else begin
      if (cfg_ok && !cfg_sel) gain_act[cfg_ch] <= i_cfg_wdata;
      if (cfg_ok && cfg_sel)  off_act[cfg_ch]  <= i_cfg_wdata;
    end
  end
`endif

  // Results that find no tag are dropped and flagged instead of popping.
  assign pop = i_fma_res_tvalid && (outstanding != '0);

  // Tag storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (fma_fire) tag_mem[wr_ptr] <= tag_q;
  end

  // Tag FIFO pointers and occupancy; push and pop in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (fma_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({fma_fire, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Result register (one cycle latency) and sticky error; setting wins over clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dest_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= pop;
      if (pop) begin
        res_data_q <= i_fma_res_tdata;
        res_dest_q <= tag_mem[rd_ptr];
      end
      if (i_fma_res_tvalid && outstanding == '0) err_q <= 1'b1;
      else if (i_err_clr)                        err_q <= 1'b0;
    end
  end

  assign o_ch_tready   = ch_ready;
  assign o_fma_a_tdata = a_q;
  assign o_fma_b_tdata = b_q;
  assign o_fma_c_tdata = c_q;
  assign o_fma_tvalid  = (state == ISSUE_HOLD) && room;
  assign o_res_tdata   = res_data_q;
  assign o_res_tdest   = res_dest_q;
  assign o_res_tvalid  = res_valid_q;
  assign o_busy        = (state == ISSUE_HOLD) || (outstanding != '0);
  assign o_err         = err_q;

endmodule

// File: tb/tb_adc_cal_sched.sv
// tb_adc_cal_sched: directed test of the FMA-sharing calibration scheduler.
// Channel feeders and an FMA model (a*b+c in real arithmetic, rounded to single)
// drive the DUT; grant and result monitors pop expected values from queues.
// Timing within a 10 ns cycle: posedge at 0, channel feeder at +1,
// main stimulus at +3, monitors and FMA model at the negedge (+5).
`timescale 1ns/1ps
module tb_adc_cal_sched;
  localparam int NUM_CH  = 4;
  localparam int MAX_OUT = 16;
  localparam int TAG_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH*32-1:0] i_ch_tdata;
  logic [NUM_CH-1:0]    i_ch_tvalid;
  logic [NUM_CH-1:0]    o_ch_tready;
  logic                 i_cfg_we;
  logic [TAG_W:0]       i_cfg_addr;
  logic [31:0]          i_cfg_wdata;
  logic                 i_cfg_commit;
  logic [31:0]          o_fma_a_tdata, o_fma_b_tdata, o_fma_c_tdata;
  logic                 o_fma_tvalid;
  logic                 i_fma_tready;
  logic [31:0]          i_fma_res_tdata;
  logic                 i_fma_res_tvalid;
  logic [31:0]          o_res_tdata;
  logic [TAG_W-1:0]     o_res_tdest;
  logic                 o_res_tvalid;
  logic                 o_busy;
  logic                 o_err;
  logic                 i_err_clr;

  adc_cal_sched #(.NUM_CH(NUM_CH), .MAX_OUT(MAX_OUT)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .i_ch_tdata(i_ch_tdata), .i_ch_tvalid(i_ch_tvalid), .o_ch_tready(o_ch_tready),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
    .i_cfg_commit(i_cfg_commit),
    .o_fma_a_tdata(o_fma_a_tdata), .o_fma_b_tdata(o_fma_b_tdata), .o_fma_c_tdata(o_fma_c_tdata),
    .o_fma_tvalid(o_fma_tvalid), .i_fma_tready(i_fma_tready),
    .i_fma_res_tdata(i_fma_res_tdata), .i_fma_res_tvalid(i_fma_res_tvalid),
    .o_res_tdata(o_res_tdata), .o_res_tdest(o_res_tdest), .o_res_tvalid(o_res_tvalid),
    .o_busy(o_busy), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [TAG_W+31:0] exp_q[$];
  logic [TAG_W-1:0]  gexp_q[$];
  logic [31:0]       ch_q[NUM_CH][$];

  // FMA model state
  logic [31:0] fma_res_q[$];
  int          fma_due_q[$];
  int          cyc = 0;
  int          fma_lat = 3;
  bit          fma_stall = 1'b0;
  bit          inject_res = 1'b0;
  int          acc_cnt = 0, res_cnt = 0, max_inflight = 0, acc_at_first_res = -1;

  // Hand-computed stimulus tables: sample per channel and the volts it maps to
  // with default coefficients (gain 1.25*2^-20, offset -10).
  logic [31:0] samp_a [NUM_CH] = '{32'h4B00_0000, 32'h4B80_0000, 32'h4C00_0000, 32'h4B40_0000};
  logic [31:0] res_a  [NUM_CH] = '{32'h0000_0000, 32'h4120_0000, 32'h41F0_0000, 32'h40A0_0000};
  logic [31:0] samp_b [NUM_CH] = '{32'h0000_0000, 32'h4B00_0000, 32'h4B80_0000, 32'h4C00_0000};
  logic [31:0] res_b  [NUM_CH] = '{32'hC120_0000, 32'h0000_0000, 32'h4120_0000, 32'h41F0_0000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic   s;
    int     e;
    real    m, fr, rem;
    longint fi;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    fr  = (m - 1.0) * 8388608.0;
    fi  = longint'($floor(fr));
    rem = fr - real'(fi);
    if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
    if (fi == 64'd8388608) begin fi = 0; e++; end
    return {s, 8'(e + 127), 23'(fi)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic cfg_write(input logic [TAG_W:0] addr, input logic [31:0] data);
    i_cfg_we = 1'b1; i_cfg_addr = addr; i_cfg_wdata = data;
    tick(1);
    i_cfg_we = 1'b0;
  endtask

  task automatic send(input int ch, input logic [31:0] s, input logic [31:0] r);
    ch_q[ch].push_back(s);
    gexp_q.push_back(TAG_W'(ch));
    exp_q.push_back({TAG_W'(ch), r});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || gexp_q.size() != 0 || o_busy || fma_res_q.size() != 0)
           && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: timeout after %0d cycles, results left %0d, grants left %0d",
               name, n, exp_q.size(), gexp_q.size());
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  // ---------------- channel feeders ----------------
  initial begin
    logic [NUM_CH-1:0] tr;
    i_ch_tvalid = '0;
    i_ch_tdata  = '0;
    forever begin
      @(negedge clk);
      tr = o_ch_tready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (tr[k] && ch_q[k].size() > 0) void'(ch_q[k].pop_front());
        i_ch_tvalid[k] = (ch_q[k].size() > 0);
        i_ch_tdata[32*k +: 32] = (ch_q[k].size() > 0) ? ch_q[k][0] : 32'h0;
      end
    end
  end

  // ---------------- monitors (scoreboard) and FMA model ----------------
  initial begin
    logic [TAG_W-1:0]  g;
    logic [TAG_W+31:0] e;
    i_fma_tready     = 1'b1;
    i_fma_res_tvalid = 1'b0;
    i_fma_res_tdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_ch_tready != '0) begin
        if (gexp_q.size() == 0) check("unexpected_grant", 32'(o_ch_tready), 32'h0);
        else begin
          g = gexp_q.pop_front();
          check("grant_onehot", 32'(o_ch_tready), 32'(1) << g);
        end
      end
      if (o_res_tvalid) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'(o_res_tvalid), 32'h0);
        else begin
          e = exp_q.pop_front();
          check("res_dest", 32'(o_res_tdest), 32'(e[TAG_W+31:32]));
          check("res_data", o_res_tdata, e[31:0]);
        end
      end
      i_fma_tready = !fma_stall;
      if (o_fma_tvalid && i_fma_tready) begin
        fma_res_q.push_back(r2f(f2r(o_fma_a_tdata) * f2r(o_fma_b_tdata) + f2r(o_fma_c_tdata)));
        fma_due_q.push_back(cyc + fma_lat);
        acc_cnt++;
      end
      i_fma_res_tvalid = 1'b0;
      if (fma_res_q.size() > 0 && fma_due_q[0] <= cyc) begin
        i_fma_res_tvalid = 1'b1;
        i_fma_res_tdata  = fma_res_q.pop_front();
        void'(fma_due_q.pop_front());
        res_cnt++;
        if (acc_at_first_res < 0) acc_at_first_res = acc_cnt;
      end else if (inject_res) begin
        i_fma_res_tvalid = 1'b1;
        i_fma_res_tdata  = 32'h1234_5678;
        inject_res = 1'b0;
      end
      if (acc_cnt - res_cnt > max_inflight) max_inflight = acc_cnt - res_cnt;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst = 1'b1;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_wdata = '0; i_cfg_commit = 1'b0;
    i_err_clr = 1'b0;
    tick(3);

    // T0: outputs while reset is held
    check("rst_ch_tready", 32'(o_ch_tready), 32'h0);
    check("rst_fma_tvalid", 32'(o_fma_tvalid), 32'h0);
    check("rst_fma_a", o_fma_a_tdata, 32'h0);
    check("rst_fma_b", o_fma_b_tdata, 32'h0);
    check("rst_fma_c", o_fma_c_tdata, 32'h0);
    check("rst_res_tvalid", 32'(o_res_tvalid), 32'h0);
    check("rst_res_tdata", o_res_tdata, 32'h0);
    check("rst_res_tdest", 32'(o_res_tdest), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    rst = 1'b0;
    tick(2);

    // T1: single sample on ch0 with default coefficients -> 0.0
    send(0, 32'h4B00_0000, 32'h0000_0000);
    wait_idle("t1_single", 200);

    // T2: all channels busy after reset -> grants 0,1,2,3,0,1,2,3
    reset_dut();
    for (int k = 0; k < NUM_CH; k++) send(k, samp_a[k], res_a[k]);
    for (int k = 0; k < NUM_CH; k++) send(k, samp_b[k], res_b[k]);
    wait_idle("t2_round_robin", 400);

    // T3: FMA stalls; held op stays put, no new grant, cfg write does not touch it
    fma_stall = 1'b1;
    send(2, 32'h4B80_0000, 32'h4120_0000);
    tick(4);
    send(1, 32'h4B40_0000, 32'h40A0_0000);
    cfg_write({2'd2, 1'b0}, 32'h3F80_0000);
    for (int i = 0; i < 5; i++) begin
      check("t3_fma_tvalid", 32'(o_fma_tvalid), 32'h1);
      check("t3_fma_a", o_fma_a_tdata, 32'h4B80_0000);
      check("t3_fma_b", o_fma_b_tdata, 32'h35A0_0000);
      check("t3_fma_c", o_fma_c_tdata, 32'hC120_0000);
      check("t3_no_grant", 32'(o_ch_tready), 32'h0);
      tick(1);
    end
    fma_stall = 1'b0;
    wait_idle("t3_stall", 200);
    cfg_write({2'd2, 1'b0}, 32'h35A0_0000);

    // T4: latency 40 -> exactly MAX_OUT in flight, grants stall until first result
    fma_lat = 40;
    acc_cnt = 0; res_cnt = 0; max_inflight = 0; acc_at_first_res = -1;
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < NUM_CH; i++) send((2 + i) % NUM_CH, samp_a[(2 + i) % NUM_CH], res_a[(2 + i) % NUM_CH]);
    wait_idle("t4_full", 3000);
    check("t4_issued_before_first_res", 32'(acc_at_first_res), 32'd16);
    check("t4_max_inflight", 32'(max_inflight), 32'd16);
    check("t4_total_issued", 32'(acc_cnt), 32'd20);
    fma_lat = 3;

    // T5: spurious result -> sticky error, no output; set beats clear
    inject_res = 1'b1;
    tick(3);
    check("t5_err_set", 32'(o_err), 32'h1);
    check("t5_busy", 32'(o_busy), 32'h0);
    i_err_clr = 1'b1;
    tick(1);
    i_err_clr = 1'b0;
    tick(1);
    check("t5_err_clr", 32'(o_err), 32'h0);
    inject_res = 1'b1;
    i_err_clr = 1'b1;
    tick(1);
    i_err_clr = 1'b0;
    tick(2);
    check("t5_set_beats_clr", 32'(o_err), 32'h1);
    i_err_clr = 1'b1;
    tick(1);
    i_err_clr = 1'b0;
    tick(1);
    check("t5_err_clr2", 32'(o_err), 32'h0);

    // T6: ch1 gain=1.0, ch3 offset=0.0; grant order from rr=1 is 3 then 1
    cfg_write({2'd1, 1'b0}, 32'h3F80_0000);
    cfg_write({2'd3, 1'b1}, 32'h0000_0000);
`ifdef CAL_COEF_SHADOW_EN
    send(3, 32'h4B40_0000, 32'h40A0_0000);
    send(1, 32'h4000_0000, 32'hC11F_FFFE);
`else
    send(3, 32'h4B40_0000, 32'h4170_0000);
    send(1, 32'h4000_0000, 32'hC100_0000);
`endif
    wait_idle("t6_before_commit", 200);
    i_cfg_commit = 1'b1;
    tick(1);
    i_cfg_commit = 1'b0;
    tick(1);
    send(3, 32'h4B40_0000, 32'h4170_0000);
    send(1, 32'h4000_0000, 32'hC100_0000);
    wait_idle("t6_after_commit", 200);

    check("final_results_drained", 32'(exp_q.size()), 32'h0);
    check("final_grants_drained", 32'(gexp_q.size()), 32'h0);
    check("final_err", 32'(o_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
